scan_chain_ctrl: RTL and testbench
==================================

# scan_chain_ctrl

Tester-side controller for one scan chain built from `scanff` cells. It serially loads a parallel test pattern through the chain's scan input, then issues one capture cycle. It then unloads the captured response from the chain's scan output into a parallel register and optionally compares it against an expected value. It sits between a BIST/pattern source and the scan port of a `dff`/`scanff` datapath, and drives that chain's SE and SI.

## Interface
- `CHAIN_LEN`, default 8: number of scan flops in the chain (≥2).
- `clock` in 1: single clock, shared with the scan chain; all state changes on rising edge.
- `reset_l` in 1: asynchronous, active-low reset.
- `start` in 1: request one load/capture/unload sequence; sampled only in IDLE.
- `pattern_in` in CHAIN_LEN: stimulus; latched on accepted `start`.
- `expect_in` in CHAIN_LEN: expected response; latched on accepted `start`.
- `scan_out` in 1: Q of the chain's last flop (position 0).
- `scan_en` out 1: drives SE of every chain flop; registered.
- `scan_in` out 1: drives SI of the chain's first flop (position CHAIN_LEN-1); registered.
- `busy` out 1: high from first SHIFT_IN cycle through last SHIFT_OUT cycle.
- `done` out 1: one-cycle pulse when the response is valid.
- `response` out CHAIN_LEN: unloaded capture data; held until next accepted `start`.
- `pass` out 1: compare result; valid when `done` rises, held with `response`.

## Operation
- Chain position p: p=0 drives `scan_out`, p=CHAIN_LEN-1 is fed by `scan_in`.
- FSM states: IDLE, SHIFT_IN, CAPTURE, SHIFT_OUT, DONE.
- IDLE: `scan_en`=0, `scan_in`=0. `start`=1 latches `pattern_in` and `expect_in`, clears the bit counter, and goes to SHIFT_IN.
- SHIFT_IN: lasts CHAIN_LEN cycles. `scan_en`=1. In shift cycle i (i=0..CHAIN_LEN-1), `scan_in`=pattern[i]. After the last edge, position p holds pattern_in[p]. Then goes to CAPTURE.
- CAPTURE: lasts 1 cycle. `scan_en`=0, `scan_in`=0. The chain loads its functional D at the closing edge. Then goes to SHIFT_OUT with the counter cleared.
- SHIFT_OUT: lasts CHAIN_LEN cycles. `scan_en`=1, `scan_in`=0. In cycle j, `scan_out` is sampled at the closing edge into response[j], so response[p] equals the captured bit of position p. Then goes to DONE.
- DONE: lasts 1 cycle. `done`=1 and `scan_en`=0. Then returns to IDLE.
- Counter: width $clog2(CHAIN_LEN). The terminal count is CHAIN_LEN-1. The counter never wraps inside a state.
- `start` while not IDLE is ignored; it is not queued. `start` held high in DONE→IDLE starts a new sequence from the IDLE cycle.
- `pattern_in` and `expect_in` changes after acceptance have no effect.

## Timing
- Reset (asynchronous assert, synchronous deassert by the user) puts outputs in these states:
  - FSM: IDLE
  - `scan_en`: 0
  - `scan_in`: 0
  - `busy`: 0
  - `done`: 0
  - `response`: 0
  - `pass`: 0
- Reset mid-sequence aborts immediately to these values. The chain contents are left undefined.
- The edge sampling `start` is E0. The sequence then runs:
  - cycles 1..N: SHIFT_IN
  - cycle N+1: CAPTURE
  - cycles N+2..2N+1: SHIFT_OUT
  - cycle 2N+2: `done`=1
  - earliest next accepted `start` edge: E(2N+3)
- `response` and `pass` update on the edge that enters DONE.
- `scan_en` and `scan_in` are flop outputs, so the chain sees no combinational path from `start`.

## Configuration
- `SCAN_CHAIN_CTRL_COMPARE_EN` defined: `pass` = (response == latched expect). The `expect_in` latch and comparator are present.
- Not defined: no expect register or comparator. `expect_in` is ignored. `pass` is 1 whenever `done`/`response` are valid and 0 after reset.

## Test plan
- Reset mid-SHIFT_IN (drop `reset_l` at cycle 3) -> all outputs 0 asynchronously, FSM in IDLE; next `start` runs a full sequence.
- N=8, bench chain of 8 `scanff` with D=Q (hold), `pattern_in`=8'hA5, `expect_in`=8'hA5 -> `done` at cycle 18 after E0, `response`=8'hA5, `pass`=1.
- N=8, chain D tied to 8'h3C, `pattern_in`=8'hFF, `expect_in`=8'h3C -> `response`=8'h3C, `pass`=1. Rerun with `expect_in`=8'h3D -> `pass`=0 (macro on) / 1 (macro off).
- `start` pulsed again at cycles 5 and 12 of a running sequence -> ignored, exactly one `done`. `start` held high continuously -> back-to-back sequences with `done` every 19 cycles.
- SHIFT_IN trace with `pattern_in`=8'b0000_0001 -> `scan_in`=1 only in shift cycle 0. `scan_en` is 1 for cycles 1–8, 0 in cycle 9, and 1 for cycles 10–17.

Source files
------------

// File: rtl/scan_chain_ctrl.sv
// scan_chain_ctrl: tester-side controller for one scan chain of scanff cells.
// Latency: start accepted at E0, done pulses in cycle 2*CHAIN_LEN+2, next start at E(2*CHAIN_LEN+3).
// Backpressure: none; start is only sampled in IDLE, and start outside IDLE is dropped, not queued.
//
// Ports:
//   clock, reset_l        - single clock shared with the chain; async active-low reset
//   start                 - request one load/capture/unload sequence (IDLE only)
//   pattern_in, expect_in - stimulus and expected response, latched when start is accepted
//   scan_out              - Q of chain position 0 (last flop)
//   scan_en, scan_in      - registered SE for all chain flops, SI for position CHAIN_LEN-1
//   busy                  - high from the first SHIFT_IN cycle through the last SHIFT_OUT cycle
//   done                  - one-cycle pulse when response/pass are valid
//   response, pass        - unloaded capture data and compare result, held until the next DONE
//
// Optional compare: define SCAN_CHAIN_CTRL_COMPARE_EN to add the expect register and
// comparator. Without it expect_in is ignored and pass reads 1 whenever a result is valid.

module scan_chain_ctrl #(
  parameter int CHAIN_LEN = 8
) (
  input  logic                 clock,
  input  logic                 reset_l,
  input  logic                 start,
  input  logic [CHAIN_LEN-1:0] pattern_in,
  input  logic [CHAIN_LEN-1:0] expect_in,
  input  logic                 scan_out,
  output logic                 scan_en,
  output logic                 scan_in,
  output logic                 busy,
  output logic                 done,
  output logic [CHAIN_LEN-1:0] response,
  output logic                 pass
);

  localparam int CNT_W = $clog2(CHAIN_LEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHAIN_LEN - 1);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_SHIFT_IN  = 3'd1;
  localparam logic [2:0] ST_CAPTURE   = 3'd2;
  localparam logic [2:0] ST_SHIFT_OUT = 3'd3;
  localparam logic [2:0] ST_DONE      = 3'd4;

  logic [2:0]           state;
  logic [CNT_W-1:0]     cnt;
  logic [CNT_W-1:0]     cnt_inc;
  logic                 cnt_last;
  logic [CHAIN_LEN-1:0] pat_q;
  logic [CHAIN_LEN-1:0] resp_acc;
  logic [CHAIN_LEN-1:0] resp_final;
  logic                 pass_nxt;

  assign cnt_inc  = cnt + 1'b1;
  assign cnt_last = (cnt == CNT_LAST);
  assign busy     = (state == ST_SHIFT_IN) || (state == ST_CAPTURE) || (state == ST_SHIFT_OUT);

  // The last unloaded bit arrives on the same edge that publishes the response,
  // so splice the live scan_out into the top position.
  always_comb begin
    resp_final                = resp_acc;
    resp_final[CHAIN_LEN-1]   = scan_out;
  end

`ifdef SCAN_CHAIN_CTRL_COMPARE_EN
  logic [CHAIN_LEN-1:0] exp_q;

  always_ff @(posedge clock or negedge reset_l) begin
    if (!reset_l) begin
      exp_q <= '0;
    end else if ((state == ST_IDLE) && start) begin
      exp_q <= expect_in;
    end
  end

  assign pass_nxt = (resp_final == exp_q);
`else
  logic unused_expect;
  assign unused_expect = ^expect_in;
  assign pass_nxt      = 1'b1;
`endif

  always_ff @(posedge clock or negedge reset_l) begin
    if (!reset_l) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      pat_q    <= '0;
      resp_acc <= '0;
      scan_en  <= 1'b0;
      scan_in  <= 1'b0;
      done     <= 1'b0;
      response <= '0;
      pass     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          scan_en <= 1'b0;
          scan_in <= 1'b0;
          done    <= 1'b0;
          if (start) begin
            pat_q   <= pattern_in;
            cnt     <= '0;
            state   <= ST_SHIFT_IN;
            scan_en <= 1'b1;
            // Bit 0 goes in first so that it ends up at position 0 after N shifts.
            scan_in <= pattern_in[0];
          end
        end

        ST_SHIFT_IN: begin
          if (cnt_last) begin
            state   <= ST_CAPTURE;
            scan_en <= 1'b0;
            scan_in <= 1'b0;
          end else begin
            cnt     <= cnt_inc;
            scan_in <= pat_q[cnt_inc];
          end
        end

        ST_CAPTURE: begin
          // Chain loads its functional D on the edge closing this cycle.
          state   <= ST_SHIFT_OUT;
          cnt     <= '0;
          scan_en <= 1'b1;
          scan_in <= 1'b0;
        end

        ST_SHIFT_OUT: begin
          resp_acc[cnt] <= scan_out;
          if (cnt_last) begin
            state    <= ST_DONE;
            scan_en  <= 1'b0;
            done     <= 1'b1;
            response <= resp_final;
            pass     <= pass_nxt;
          end else begin
            cnt <= cnt_inc;
          end
        end

        ST_DONE: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end

        default: begin
          state   <= ST_IDLE;
          scan_en <= 1'b0;
          scan_in <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// tb_scan_chain_ctrl: bench for scan_chain_ctrl with an 8-flop scanff chain model.
// Latency: checks done arrives in cycle 2N+2 after the accepting edge.
// Backpressure: none in the DUT; start pulses during a sequence must be dropped.

module tb_scan_chain_ctrl;

  localparam int N = 8;

`ifdef SCAN_CHAIN_CTRL_COMPARE_EN
  localparam bit CMP = 1'b1;
`else
  localparam bit CMP = 1'b0;
`endif

  logic         clock = 1'b0;
  logic         reset_l;
  logic         start;
  logic [N-1:0] pattern_in;
  logic [N-1:0] expect_in;
  logic         scan_out;
  logic         scan_en;
  logic         scan_in;
  logic         busy;
  logic         done;
  logic [N-1:0] response;
  logic         pass;

  scan_chain_ctrl #(.CHAIN_LEN(N)) dut (
    .clock      (clock),
    .reset_l    (reset_l),
    .start      (start),
    .pattern_in (pattern_in),
    .expect_in  (expect_in),
    .scan_out   (scan_out),
    .scan_en    (scan_en),
    .scan_in    (scan_in),
    .busy       (busy),
    .done       (done),
    .response   (response),
    .pass       (pass)
  );

  always #5 clock = ~clock;

  // Chain of scanff cells: SE=1 shifts toward position 0, SE=0 loads functional D
  // which is either the flop's own Q (hold) or a tied constant.
  logic [N-1:0] chain;
  bit           chain_hold;
  logic [N-1:0] chain_d;

  always @(posedge clock) begin
    if (scan_en) chain <= {scan_in, chain[N-1:1]};
    else         chain <= chain_hold ? chain : chain_d;
  end
  assign scan_out = chain[0];

  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One full sequence; expected values come from the caller.
  task automatic run_seq(input logic [N-1:0] pat, input logic [N-1:0] exp,
                         input bit hold, input logic [N-1:0] dc,
                         input logic [N-1:0] want_resp, input bit want_pass,
                         input string tag);
    int cyc;
    chain_hold = hold;
    chain_d    = dc;
    tick();
    pattern_in = pat;
    expect_in  = exp;
    start      = 1'b1;
    tick();                          // E0 has been taken; now in cycle 1
    start      = 1'b0;
    pattern_in = N'($urandom);       // late changes must not matter
    expect_in  = N'($urandom);
    cyc = 1;
    while (!done && cyc < 100) begin
      tick();
      cyc++;
    end
    check({tag, ".done_cycle"}, 32'(cyc), 32'(2*N+2));
    check({tag, ".response"}, 32'(response), 32'(want_resp));
    check({tag, ".pass"}, 32'(pass), 32'(want_pass));
  endtask

  typedef struct {
    logic [N-1:0] pat;
    logic [N-1:0] exp;
    bit           hold;
    logic [N-1:0] dc;
    logic [N-1:0] resp;
    bit           pass_on;
    bit           pass_off;
  } vec_t;

  vec_t tbl[5];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    int dq[$];
    int dones;

    tbl[0] = '{8'hA5, 8'hA5, 1'b1, 8'h00, 8'hA5, 1'b1, 1'b1};
    tbl[1] = '{8'hFF, 8'h3C, 1'b0, 8'h3C, 8'h3C, 1'b1, 1'b1};
    tbl[2] = '{8'hFF, 8'h3D, 1'b0, 8'h3C, 8'h3C, 1'b0, 1'b1};
    tbl[3] = '{8'h00, 8'h00, 1'b1, 8'hFF, 8'h00, 1'b1, 1'b1};
    tbl[4] = '{8'h5A, 8'h00, 1'b0, 8'h81, 8'h81, 1'b0, 1'b1};

    reset_l    = 1'b0;
    start      = 1'b0;
    pattern_in = '0;
    expect_in  = '0;
    chain_hold = 1'b1;
    chain_d    = '0;

    // Reset state, before any clock edge
    #3;
    check("rst.scan_en", 32'(scan_en), 0);
    check("rst.scan_in", 32'(scan_in), 0);
    check("rst.busy", 32'(busy), 0);
    check("rst.done", 32'(done), 0);
    check("rst.response", 32'(response), 0);
    check("rst.pass", 32'(pass), 0);
    tick();
    tick();
    reset_l = 1'b1;

    // Table-driven vectors
    for (int i = 0; i < 5; i++) begin
      run_seq(tbl[i].pat, tbl[i].exp, tbl[i].hold, tbl[i].dc, tbl[i].resp,
              CMP ? tbl[i].pass_on : tbl[i].pass_off, $sformatf("tbl%0d", i));
    end

    // SHIFT_IN / CAPTURE / SHIFT_OUT trace with a single one in bit 0
    chain_hold = 1'b1;
    tick();
    pattern_in = 8'b0000_0001;
    expect_in  = 8'b0000_0001;
    start      = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 2*N+1; k++) begin
      check($sformatf("trace.scan_en[c%0d]", k), 32'(scan_en), 32'((k <= N) || (k >= N+2)));
      check($sformatf("trace.scan_in[c%0d]", k), 32'(scan_in), 32'(k == 1));
      check($sformatf("trace.busy[c%0d]", k), 32'(busy), 1);
      check($sformatf("trace.done[c%0d]", k), 32'(done), 0);
      tick();
    end
    check("trace.done_final", 32'(done), 1);
    check("trace.busy_final", 32'(busy), 0);
    check("trace.scan_en_final", 32'(scan_en), 0);
    check("trace.response", 32'(response), 32'h01);

    // Reset in the middle of SHIFT_IN (cycle 3)
    tick();
    pattern_in = 8'hA5;
    start      = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    #2;
    reset_l = 1'b0;
    #1;
    check("midrst.scan_en", 32'(scan_en), 0);
    check("midrst.scan_in", 32'(scan_in), 0);
    check("midrst.busy", 32'(busy), 0);
    check("midrst.done", 32'(done), 0);
    check("midrst.response", 32'(response), 0);
    check("midrst.pass", 32'(pass), 0);
    tick();
    reset_l = 1'b1;
    run_seq(8'h3C, 8'h3C, 1'b1, 8'h00, 8'h3C, 1'b1, "after_rst");

    // start pulses at cycles 5 and 12 must be ignored
    chain_hold = 1'b1;
    tick();
    pattern_in = 8'h96;
    expect_in  = 8'h96;
    start      = 1'b1;
    tick();
    dones = 0;
    for (int k = 1; k <= 40; k++) begin
      start = (k == 5) || (k == 12);
      if (done) dones++;
      tick();
    end
    start = 1'b0;
    check("ignore.done_count", 32'(dones), 1);
    check("ignore.response", 32'(response), 32'h96);

    // start held high: back-to-back sequences every 2N+3 cycles
    tick();
    pattern_in = 8'h6B;
    expect_in  = 8'h6B;
    start      = 1'b1;
    for (int k = 1; k <= 70; k++) begin
      tick();
      if (done) dq.push_back(k);
    end
    start = 1'b0;
    check("held.done_count", 32'(dq.size()), 3);
    for (int i = 0; i < dq.size() && i < 3; i++)
      check($sformatf("held.done_cycle%0d", i), 32'(dq[i]), 32'(2*N+2 + i*(2*N+3)));
    check("held.response", 32'(response), 32'h6B);
    begin
      int w = 0;
      while (!done && w < 60) begin
        tick();
        w++;
      end
      check("held.drain", 32'(w < 60), 1);
    end

    // Randomized vectors against a value-level model of the chain
    for (int i = 0; i < 24; i++) begin
      logic [N-1:0] pat, dc, exp, mresp;
      bit           hold, mpass;
      pat   = N'($urandom);
      dc    = N'($urandom);
      hold  = 1'($urandom_range(0, 1));
      mresp = hold ? pat : dc;
      exp   = ($urandom_range(0, 1) == 1) ? mresp : N'($urandom);
      mpass = CMP ? (mresp == exp) : 1'b1;
      run_seq(pat, exp, hold, dc, mresp, mpass, $sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
